// File: rtl/uart_bus_master.sv
// UART-to-peripheral-bus initiator for board bring-up.
// Receives W/R command frames on rx, performs one bus access per frame,
// and answers on tx: 'K' after a write, 4 data bytes after a read, 'E' on a bad frame.
module uart_bus_master #(
   parameter int CLKS_PER_BIT = 1021,
   parameter int TIMEOUT_CLKS = 1_176_470
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic        tx,
   output logic [4:0]  A,
   output logic [31:0] WD,
   output logic        WE,
   input  logic [31:0] RD,
   output logic        bus_active,
   output logic        frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT_CLKS);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

   localparam logic [7:0] CMD_W  = 8'h57;
   localparam logic [7:0] CMD_R  = 8'h52;
   localparam logic [7:0] RESP_K = 8'h4B;
   localparam logic [7:0] RESP_E = 8'h45;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_GET_ADDR = 3'd1;
   localparam logic [2:0] S_GET_DATA = 3'd2;
   localparam logic [2:0] S_BUS_WR   = 3'd3;
   localparam logic [2:0] S_BUS_RD   = 3'd4;
   localparam logic [2:0] S_ERR_RESP = 3'd5;
   localparam logic [2:0] S_SEND     = 3'd6;

   logic          rx_meta_r, rx_sync_r, rx_prev_r;
   logic [1:0]    rx_state_r;
   logic [CW-1:0] rx_cnt_r;
   logic [2:0]    rx_bit_r;
   logic [7:0]    rx_shift_r, rx_byte_r;
   logic          rx_valid_r, rx_err_r;

   logic          tx_r, tx_busy_r, tx_start_s;
   logic [8:0]    tx_shift_r;
   logic [CW-1:0] tx_cnt_r;
   logic [3:0]    tx_bit_r;

   logic [2:0]    state_r;
   logic          is_wr_r;
   logic [4:0]    a_r;
   logic [31:0]   wd_r, resp_r;
   logic          we_r, bus_active_r, ferr_r;
   logic [1:0]    byte_cnt_r;
   logic [TW-1:0] tmo_r;
   logic [2:0]    resp_left_r;

   assign tx         = tx_r;
   assign A          = a_r;
   assign WD         = wd_r;
   assign WE         = we_r;
   assign bus_active = bus_active_r;
   assign frame_err  = ferr_r;

   // Two-flop synchronizer for the async rx line plus one delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // UART receiver: start-bit check at half bit, then data and stop sampled at bit centres.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= '0;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'h00;
         rx_byte_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               rx_cnt_r <= '0;
               if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
            end
            RX_START: begin
               if (rx_cnt_r == HALF_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_bit_r   <= 3'd0;
                  // line back high at mid start bit means it was only a glitch
                  rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_r <= rx_cnt_r + CW'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                  if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
                  else                  rx_bit_r   <= rx_bit_r + 3'd1;
               end else begin
                  rx_cnt_r <= rx_cnt_r + CW'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_state_r <= RX_IDLE;
                  if (rx_sync_r) begin
                     rx_valid_r <= 1'b1;
                     rx_byte_r  <= rx_shift_r;
                  end else begin
                     rx_err_r <= 1'b1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CW'(1);
               end
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

   // Launch the next queued response byte whenever SEND finds the transmitter free.
   always_comb begin
      tx_start_s = 1'b0;
      if (state_r == S_SEND && !tx_busy_r && resp_left_r != 3'd0) tx_start_s = 1'b1;
      else                                                         tx_start_s = 1'b0;
   end

   // UART transmitter: start bit, 8 data bits LSB first, stop bit; tx is a registered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_r       <= 1'b1;
         tx_busy_r  <= 1'b0;
         tx_shift_r <= 9'h1FF;
         tx_cnt_r   <= '0;
         tx_bit_r   <= 4'd0;
      end else if (tx_start_s) begin
         tx_r       <= 1'b0;
         tx_shift_r <= {1'b1, resp_r[7:0]};
         tx_cnt_r   <= '0;
         tx_bit_r   <= 4'd0;
         tx_busy_r  <= 1'b1;
      end else if (tx_busy_r) begin
         if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r <= '0;
            if (tx_bit_r == 4'd9) begin
               tx_busy_r <= 1'b0;
               tx_r      <= 1'b1;
            end else begin
               tx_r       <= tx_shift_r[0];
               tx_shift_r <= {1'b1, tx_shift_r[8:1]};
               tx_bit_r   <= tx_bit_r + 4'd1;
            end
         end else begin
            tx_cnt_r <= tx_cnt_r + CW'(1);
         end
      end
   end

   // Frame decoder and bus sequencer; WE/bus_active are set on entry so they are high for exactly the access cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         is_wr_r      <= 1'b0;
         a_r          <= 5'd0;
         wd_r         <= 32'h0;
         we_r         <= 1'b0;
         bus_active_r <= 1'b0;
         ferr_r       <= 1'b0;
         byte_cnt_r   <= 2'd0;
         tmo_r        <= '0;
         resp_r       <= 32'h0;
         resp_left_r  <= 3'd0;
      end else begin
         we_r         <= 1'b0;
         bus_active_r <= 1'b0;
         ferr_r       <= rx_err_r;   // a framing error always drops the byte
         case (state_r)
            S_IDLE: begin
               if (rx_valid_r) begin
                  if (rx_byte_r == CMD_W || rx_byte_r == CMD_R) begin
                     is_wr_r <= (rx_byte_r == CMD_W);
                     tmo_r   <= '0;
                     state_r <= S_GET_ADDR;
                  end else begin
                     state_r <= S_ERR_RESP;
                  end
               end
            end
            S_GET_ADDR: begin
               if (rx_err_r) begin
                  state_r <= S_IDLE;
               end else if (rx_valid_r) begin
                  tmo_r <= '0;
                  if (rx_byte_r[7:5] != 3'b000) begin
                     state_r <= S_ERR_RESP;
                  end else begin
                     a_r <= rx_byte_r[4:0];
                     if (is_wr_r) begin
                        byte_cnt_r <= 2'd0;
                        state_r    <= S_GET_DATA;
                     end else begin
                        bus_active_r <= 1'b1;
                        state_r      <= S_BUS_RD;
                     end
                  end
               end else if (tmo_r == TMO_LAST) begin
                  ferr_r  <= 1'b1;
                  state_r <= S_IDLE;
               end else begin
                  tmo_r <= tmo_r + TW'(1);
               end
            end
            S_GET_DATA: begin
               if (rx_err_r) begin
                  state_r <= S_IDLE;
               end else if (rx_valid_r) begin
                  tmo_r <= '0;
                  wd_r[{byte_cnt_r, 3'b000} +: 8] <= rx_byte_r;
                  if (byte_cnt_r == 2'd3) begin
                     we_r         <= 1'b1;
                     bus_active_r <= 1'b1;
                     state_r      <= S_BUS_WR;
                  end else begin
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                  end
               end else if (tmo_r == TMO_LAST) begin
                  ferr_r  <= 1'b1;
                  state_r <= S_IDLE;
               end else begin
                  tmo_r <= tmo_r + TW'(1);
               end
            end
            S_BUS_WR: begin
               resp_r      <= {24'h000000, RESP_K};
               resp_left_r <= 3'd1;
               state_r     <= S_SEND;
            end
            S_BUS_RD: begin
               resp_r      <= RD;
               resp_left_r <= 3'd4;
               state_r     <= S_SEND;
            end
            S_ERR_RESP: begin
               resp_r      <= {24'h000000, RESP_E};
               resp_left_r <= 3'd1;
               ferr_r      <= 1'b1;
               state_r     <= S_SEND;
            end
            S_SEND: begin
               if (tx_start_s) begin
                  resp_r      <= {8'h00, resp_r[31:8]};
                  resp_left_r <= resp_left_r - 3'd1;
               end else if (!tx_busy_r && resp_left_r == 3'd0) begin
                  state_r <= S_IDLE;
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: UART frames in, scoreboard queues for bus cycles and tx bytes.
module tb_uart_bus_master;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic        tx;
   logic [4:0]  A;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;
   logic        bus_active;
   logic        frame_err;

   typedef struct packed {
      logic        we;
      logic [4:0]  a;
      logic [31:0] wd;
   } bus_t;

   bus_t       exp_bus[$];
   logic [7:0] exp_tx[$];

   int total = 0;
   int bad = 0;
   int ferr_cnt = 0;
   int rst_epoch = 0;

   // peripheral model: read data is a pure function of the address
   function automatic logic [31:0] rd_model(input logic [4:0] a);
      return (a == 5'd8) ? 32'hDEADBEEF : (32'h0BAD0000 | {27'd0, a});
   endfunction

   assign RD = rd_model(A);

   uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(2000)) dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx), .A(A), .WD(WD), .WE(WE),
      .RD(RD), .bus_active(bus_active), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // count frame_err pulses
   always @(negedge clk) begin
      if (!rst && frame_err === 1'b1) ferr_cnt++;
   end

   // bus monitor: each access cycle must match the next expected access
   always @(negedge clk) begin
      bus_t e;
      if (!rst) begin
         if (WE === 1'b1) check("we_outside_access", bus_active, 1'b1);
         if (bus_active === 1'b1) begin
            check("bus_cycle_expected", exp_bus.size() != 0, 1'b1);
            if (exp_bus.size() != 0) begin
               e = exp_bus.pop_front();
               check("bus_we", WE, e.we);
               check("bus_addr", A, e.a);
               if (e.we) check("bus_wd", WD, e.wd);
            end
         end
      end
   end

   // tx monitor: decode 8N1 at bit centres and compare with the scoreboard
   initial begin
      forever begin
         logic [7:0] b;
         logic       s;
         int         ep;
         @(negedge tx);
         ep = rst_epoch;
         repeat (CPB / 2) @(negedge clk);
         s = tx;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         if (ep == rst_epoch && !rst) begin
            check("tx_start_bit", s, 1'b0);
            check("tx_stop_bit", tx, 1'b1);
            check("tx_byte_expected", exp_tx.size() != 0, 1'b1);
            if (exp_tx.size() != 0) check("tx_byte", b, exp_tx.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_tx_pending", exp_tx.size(), 0);
      check("drain_bus_pending", exp_bus.size(), 0);
      repeat (40) @(negedge clk);
   endtask

   initial begin
      int n;
      // reset values
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_A", A, 5'd0);
      check("rst_WD", WD, 32'h0);
      check("rst_WE", WE, 1'b0);
      check("rst_bus_active", bus_active, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // write frame
      exp_bus.push_back({1'b1, 5'd4, 32'h12345678});
      exp_tx.push_back(8'h4B);
      send_byte(8'h57, 1'b1); send_byte(8'h04, 1'b1);
      send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
      drain(1000);
      check("wr_ferr_cnt", ferr_cnt, 0);

      // read frame
      exp_bus.push_back({1'b0, 5'd8, 32'h0});
      exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hAD); exp_tx.push_back(8'hDE);
      send_byte(8'h52, 1'b1); send_byte(8'h08, 1'b1);
      drain(3000);
      check("rd_ferr_cnt", ferr_cnt, 0);

      // bad command
      exp_tx.push_back(8'h45);
      send_byte(8'h41, 1'b1);
      drain(1000);
      check("badcmd_ferr_cnt", ferr_cnt, 1);

      // bad address
      exp_tx.push_back(8'h45);
      send_byte(8'h52, 1'b1); send_byte(8'h20, 1'b1);
      drain(1000);
      check("badaddr_ferr_cnt", ferr_cnt, 2);

      // framing error on ADDR byte: no tx, no bus cycle
      send_byte(8'h52, 1'b1); send_byte(8'h04, 1'b0);
      repeat (300) @(negedge clk);
      check("framing_ferr_cnt", ferr_cnt, 3);

      // 4-clock glitch: nothing accepted
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      check("glitch_ferr_cnt", ferr_cnt, 3);

      // timeout mid-frame
      send_byte(8'h57, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h11, 1'b1);
      n = 0;
      while (ferr_cnt == 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_ferr_cnt", ferr_cnt, 4);
      check("timeout_window", (n >= 1900 && n <= 2050), 1'b1);
      repeat (20) @(negedge clk);

      // next read after timeout completes normally
      exp_bus.push_back({1'b0, 5'd0, 32'h0});
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'hAD); exp_tx.push_back(8'h0B);
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1);
      drain(3000);
      check("after_timeout_ferr_cnt", ferr_cnt, 4);

      // reset in the middle of the second response byte
      exp_bus.push_back({1'b0, 5'd8, 32'h0});
      exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hAD); exp_tx.push_back(8'hDE);
      send_byte(8'h52, 1'b1); send_byte(8'h08, 1'b1);
      n = 0;
      while (exp_tx.size() > 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_first_byte_seen", exp_tx.size(), 3);
      repeat (80) @(negedge clk);
      rst = 1'b1;
      rst_epoch++;
      exp_tx.delete();
      @(negedge clk);
      check("rst_mid_tx_high", tx, 1'b1);
      check("rst_mid_bus_active", bus_active, 1'b0);
      rst = 1'b0;
      repeat (600) @(negedge clk);
      check("rst_mid_tx_idle", tx, 1'b1);

      // frame after reset works
      exp_bus.push_back({1'b1, 5'd3, 32'hCAFEF00D});
      exp_tx.push_back(8'h4B);
      send_byte(8'h57, 1'b1); send_byte(8'h03, 1'b1);
      send_byte(8'h0D, 1'b1); send_byte(8'hF0, 1'b1);
      send_byte(8'hFE, 1'b1); send_byte(8'hCA, 1'b1);
      drain(1000);
      check("final_ferr_cnt", ferr_cnt, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
